// File: rtl/cr_xp10_decomp_lz77_hb_mp_pkg.sv
// Shared XP10 decompressor types: history-buffer read target tags
// and default buffer geometry.
package cr_xp10_decompPKG;

    localparam int CR_LZ_PRFX_SZ = 64;
    localparam int HB_DEPTH_DFLT = 4096;
    localparam int NUM_PFX_DFLT  = 3;
    localparam int DW_DFLT       = 128;
    localparam int TGT_W         = 4;

    typedef enum logic [TGT_W-1:0] {
        TGT_PFX0, TGT_PFX1, TGT_PFX2, TGT_PFX3,
        TGT_PFX4, TGT_PFX5, TGT_PFX6, TGT_PFX7,
        TGT_HB
    } tgt_e;

    function automatic tgt_e pfx_tgt(input int s);
        return tgt_e'(TGT_W'(s));
    endfunction

endpackage

// File: rtl/cr_xp10_decomp_hb_rdpipe.sv
// Read return path: target tag pipeline, same-cycle write forwarding,
// RAM output mux and registered read data / valid.
module cr_xp10_decomp_hb_rdpipe
    import cr_xp10_decompPKG::*;
#(
    parameter int DW      = 128,
    parameter int AW      = 12,
    parameter int NUM_PFX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  tgt_e                  rd_tgt,
    input  logic [AW-1:0]         rd_off,
    input  logic                  fwd_we,
    input  logic [AW-1:0]         fwd_waddr,
    input  logic [DW-1:0]         fwd_wdata,
    input  logic [DW-1:0]         hb_rdata,
    input  logic [NUM_PFX*DW-1:0] pfx_rdata,
    output logic [DW-1:0]         ag_rdata,
    output logic                  ag_rvalid
);

    logic          v1_q, v1_d;
    tgt_e          tag1_q, tag1_d;
    logic          fwd1_q, fwd1_d;
    logic [DW-1:0] fdata1_q, fdata1_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] ram_sel;

    always_comb begin
        v1_d     = rd;
        tag1_d   = rd ? rd_tgt : tag1_q;
        fwd1_d   = rd && fwd_we && (fwd_waddr == rd_off);
        fdata1_d = fwd1_d ? fwd_wdata : fdata1_q;
        ram_sel  = hb_rdata;
        for (int s = 0; s < NUM_PFX; s++) begin
            if (tag1_q == pfx_tgt(s)) ram_sel = pfx_rdata[s*DW +: DW];
        end
        rvalid_d = v1_q;
        // forwarded data wins over the RAM's read-first output
        rdata_d  = v1_q ? (fwd1_q ? fdata1_q : ram_sel) : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            tag1_q   <= TGT_HB;
            fwd1_q   <= 1'b0;
            fdata1_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            v1_q     <= v1_d;
            tag1_q   <= tag1_d;
            fwd1_q   <= fwd1_d;
            fdata1_q <= fdata1_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ag_rdata  = rdata_q;
    assign ag_rvalid = rvalid_q;

endmodule

// File: rtl/nx_ram_1r1w.sv
// Behavioural 1-read/1-write synchronous RAM, read-first on collision.
// Registered read data; no ECC protection in this model.
module nx_ram_1r1w #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata,
    output logic                     ecc_uncor
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata     = rdata_q;
    assign ecc_uncor = 1'b0;

endmodule

// File: rtl/cr_xp10_decomp_lz77_hb_mp.sv
// LZ77 history buffer: main RAM plus NUM_PFX selectable prefix RAMs,
// AG/PL write arbitration and an internally owned user write pointer.
module cr_xp10_decomp_lz77_hb_mp
    import cr_xp10_decompPKG::*;
#(
    parameter int DW        = DW_DFLT,
    parameter int HB_DEPTH  = HB_DEPTH_DFLT,
    parameter int PFX_DEPTH = CR_LZ_PRFX_SZ,
    parameter int NUM_PFX   = NUM_PFX_DFLT,
    localparam int AW       = $clog2(HB_DEPTH),
    localparam int PAW      = $clog2(PFX_DEPTH),
    localparam int SW       = (NUM_PFX > 1) ? $clog2(NUM_PFX) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ag_wr,
    input  logic [AW-1:0]          ag_waddr,
    input  logic [DW-1:0]          ag_wdata,
    input  logic                   ag_rd,
    input  logic [AW-1:0]          ag_raddr,
    output logic [DW-1:0]          ag_rdata,
    output logic                   ag_rvalid,
    input  logic                   ag_eof,
    input  logic                   pfx_sel_valid,
    input  logic [SW-1:0]          pfx_sel,
    input  logic [NUM_PFX-1:0]     pl_pfx_wr,
    input  logic [NUM_PFX*PAW-1:0] pl_pfx_waddr,
    input  logic [NUM_PFX*DW-1:0]  pl_pfx_wdata,
    output logic [NUM_PFX-1:0]     pl_pfx_ack,
    input  logic                   pl_usr_wr,
    input  logic [DW-1:0]          pl_usr_wdata,
    output logic                   pl_usr_ack,
    output logic [AW-1:0]          usr_waddr,
    output logic                   usr_wrapped,
    output logic [NUM_PFX:0]       ecc_err
);

    function automatic logic in_pfx(input logic [AW-1:0] a);
        return pfx_sel_valid && (a < AW'(PFX_DEPTH)) && (int'(pfx_sel) < NUM_PFX);
    endfunction

    logic                  ag_w_pfx, ag_w_hb, ag_r_pfx;
    logic                  hb_we, hb_re, hb_ecc;
    logic [AW-1:0]         hb_waddr;
    logic [DW-1:0]         hb_wdata, hb_rdata;
    logic [NUM_PFX-1:0]    ag_w_slot, pfx_we, pfx_re, pfx_ecc;
    logic [PAW-1:0]        pfx_waddr [NUM_PFX];
    logic [DW-1:0]         pfx_wdata [NUM_PFX];
    logic [NUM_PFX*DW-1:0] pfx_rdata;
    tgt_e                  rd_tgt;
    logic [AW-1:0]         rd_off, fwd_waddr;
    logic                  fwd_we;
    logic [DW-1:0]         fwd_wdata;
    logic [AW-1:0]         usr_waddr_q, usr_waddr_d;
    logic                  usr_wrapped_q, usr_wrapped_d;
    logic [NUM_PFX:0]      ecc_q, ecc_d;

    always_comb begin
        ag_w_pfx   = in_pfx(ag_waddr);
        ag_r_pfx   = in_pfx(ag_raddr);
        ag_w_hb    = ag_wr && !ag_w_pfx;
        pl_usr_ack = pl_usr_wr && !ag_w_hb && !rst;
        hb_we      = ag_w_hb || pl_usr_ack;
        hb_re      = ag_rd && !ag_r_pfx;
        hb_waddr   = ag_w_hb ? ag_waddr : usr_waddr_q;
        hb_wdata   = ag_w_hb ? ag_wdata : pl_usr_wdata;
        pl_pfx_ack = '0;
        for (int s = 0; s < NUM_PFX; s++) begin
            ag_w_slot[s]  = ag_wr && ag_w_pfx && (int'(pfx_sel) == s);
            pl_pfx_ack[s] = pl_pfx_wr[s] && !ag_w_slot[s] && !rst;
            pfx_we[s]     = ag_w_slot[s] || pl_pfx_ack[s];
            pfx_re[s]     = ag_rd && ag_r_pfx && (int'(pfx_sel) == s);
            pfx_waddr[s]  = ag_w_slot[s] ? ag_waddr[PAW-1:0]
                                         : pl_pfx_waddr[s*PAW +: PAW];
            pfx_wdata[s]  = ag_w_slot[s] ? ag_wdata : pl_pfx_wdata[s*DW +: DW];
        end
        rd_tgt    = ag_r_pfx ? pfx_tgt(int'(pfx_sel)) : TGT_HB;
        rd_off    = ag_r_pfx ? AW'(ag_raddr[PAW-1:0]) : ag_raddr;
        fwd_we    = hb_we;
        fwd_waddr = hb_waddr;
        fwd_wdata = hb_wdata;
        for (int s = 0; s < NUM_PFX; s++) begin
            if (ag_r_pfx && (int'(pfx_sel) == s)) begin
                fwd_we    = pfx_we[s];
                fwd_waddr = AW'(pfx_waddr[s]);
                fwd_wdata = pfx_wdata[s];
            end
        end
        usr_waddr_d   = usr_waddr_q;
        usr_wrapped_d = usr_wrapped_q;
        if (ag_eof) begin
            usr_waddr_d   = AW'(PFX_DEPTH);
            usr_wrapped_d = 1'b0;
        end else if (pl_usr_ack) begin
            if (usr_waddr_q == AW'(HB_DEPTH - 1)) begin
                usr_waddr_d   = AW'(PFX_DEPTH);
                usr_wrapped_d = 1'b1;
            end else begin
                usr_waddr_d = usr_waddr_q + AW'(1);
            end
        end
        ecc_d = {hb_ecc, pfx_ecc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            usr_waddr_q   <= AW'(PFX_DEPTH);
            usr_wrapped_q <= 1'b0;
            ecc_q         <= '0;
        end else begin
            usr_waddr_q   <= usr_waddr_d;
            usr_wrapped_q <= usr_wrapped_d;
            ecc_q         <= ecc_d;
        end
    end

    assign usr_waddr   = usr_waddr_q;
    assign usr_wrapped = usr_wrapped_q;
    assign ecc_err     = ecc_q;

    nx_ram_1r1w #(.WIDTH(DW), .DEPTH(HB_DEPTH)) u_hb_ram (
        .clk       (clk),
        .we        (hb_we),
        .waddr     (hb_waddr),
        .wdata     (hb_wdata),
        .re        (hb_re),
        .raddr     (ag_raddr),
        .rdata     (hb_rdata),
        .ecc_uncor (hb_ecc)
    );

    for (genvar g = 0; g < NUM_PFX; g++) begin : g_pfx
        nx_ram_1r1w #(.WIDTH(DW), .DEPTH(PFX_DEPTH)) u_pfx_ram (
            .clk       (clk),
            .we        (pfx_we[g]),
            .waddr     (pfx_waddr[g]),
            .wdata     (pfx_wdata[g]),
            .re        (pfx_re[g]),
            .raddr     (ag_raddr[PAW-1:0]),
            .rdata     (pfx_rdata[g*DW +: DW]),
            .ecc_uncor (pfx_ecc[g])
        );
    end

    cr_xp10_decomp_hb_rdpipe #(.DW(DW), .AW(AW), .NUM_PFX(NUM_PFX)) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .rd        (ag_rd),
        .rd_tgt    (rd_tgt),
        .rd_off    (rd_off),
        .fwd_we    (fwd_we),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .hb_rdata  (hb_rdata),
        .pfx_rdata (pfx_rdata),
        .ag_rdata  (ag_rdata),
        .ag_rvalid (ag_rvalid)
    );

endmodule

// File: tb/tb_cr_xp10_decomp_lz77_hb_mp.sv
// Bench for the XP10 LZ77 history buffer: directed vector table, pointer
// wrap / eof and reset sequences, then random traffic against a memory model.
module tb_cr_xp10_decomp_lz77_hb_mp;

    localparam int DW  = 128;
    localparam int HBD = 4096;
    localparam int PD  = 64;
    localparam int NP  = 3;
    localparam int AW  = 12;
    localparam int PAW = 6;
    localparam int SW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             ag_wr, ag_rd, ag_eof;
    logic [AW-1:0]    ag_waddr, ag_raddr;
    logic [DW-1:0]    ag_wdata, ag_rdata;
    logic             ag_rvalid;
    logic             pfx_sel_valid;
    logic [SW-1:0]    pfx_sel;
    logic [NP-1:0]    pl_pfx_wr, pl_pfx_ack;
    logic [NP*PAW-1:0] pl_pfx_waddr;
    logic [NP*DW-1:0] pl_pfx_wdata;
    logic             pl_usr_wr, pl_usr_ack;
    logic [DW-1:0]    pl_usr_wdata;
    logic [AW-1:0]    usr_waddr;
    logic             usr_wrapped;
    logic [NP:0]      ecc_err;

    cr_xp10_decomp_lz77_hb_mp #(
        .DW(DW), .HB_DEPTH(HBD), .PFX_DEPTH(PD), .NUM_PFX(NP)
    ) dut (
        .clk(clk), .rst(rst),
        .ag_wr(ag_wr), .ag_waddr(ag_waddr), .ag_wdata(ag_wdata),
        .ag_rd(ag_rd), .ag_raddr(ag_raddr),
        .ag_rdata(ag_rdata), .ag_rvalid(ag_rvalid), .ag_eof(ag_eof),
        .pfx_sel_valid(pfx_sel_valid), .pfx_sel(pfx_sel),
        .pl_pfx_wr(pl_pfx_wr), .pl_pfx_waddr(pl_pfx_waddr),
        .pl_pfx_wdata(pl_pfx_wdata), .pl_pfx_ack(pl_pfx_ack),
        .pl_usr_wr(pl_usr_wr), .pl_usr_wdata(pl_usr_wdata),
        .pl_usr_ack(pl_usr_ack), .usr_waddr(usr_waddr),
        .usr_wrapped(usr_wrapped), .ecc_err(ecc_err)
    );

    int vecs = 0;
    int errs = 0;

    // reference model state
    logic [DW-1:0] m_hb [HBD];
    bit            k_hb [HBD];
    logic [DW-1:0] m_pf [NP][PD];
    bit            k_pf [NP][PD];
    int            ptr;
    bit            wrp;
    bit            p1_v, p1_k, last_k, exp_rv;
    logic [DW-1:0] p1_d, last_d;
    bit            seen_uack;
    logic [NP-1:0] seen_pack;

    typedef struct {
        bit            sv;
        int            sel;
        bit            agw;
        int            wa;
        logic [DW-1:0] wd;
        bit            agr;
        int            ra;
        bit            uw;
        logic [DW-1:0] ud;
        logic [2:0]    pw;
        bit            eu;
        logic [2:0]    ep;
        bit            erv;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(bit sv, int sel, bit agw, int wa,
                                logic [DW-1:0] wd, bit agr, int ra,
                                bit uw, logic [DW-1:0] ud, logic [2:0] pw,
                                bit eu, logic [2:0] ep, bit erv,
                                logic [DW-1:0] erd);
        vec_t v;
        v.sv = sv; v.sel = sel; v.agw = agw; v.wa = wa; v.wd = wd;
        v.agr = agr; v.ra = ra; v.uw = uw; v.ud = ud; v.pw = pw;
        v.eu = eu; v.ep = ep; v.erv = erv; v.erd = erd;
        return v;
    endfunction

    function automatic void chk(string n, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
        end
    endfunction

    function automatic bit routes_pfx(logic [AW-1:0] a);
        return pfx_sel_valid && (int'(a) < PD) && (int'(pfx_sel) < NP);
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; ag_wr = 1'b0; ag_rd = 1'b0; ag_eof = 1'b0;
        ag_waddr = '0; ag_raddr = '0; ag_wdata = '0;
        pl_usr_wr = 1'b0; pl_usr_wdata = '0;
        pl_pfx_wr = '0; pl_pfx_waddr = '0; pl_pfx_wdata = '0;
    endtask

    // one clock: check acks, update model, check registered outputs
    task automatic step();
        bit            apw, apr, ag_hb, rv, rk;
        bit            eu;
        logic [NP-1:0] ep;
        logic [DW-1:0] rd;
        #1;
        apw   = routes_pfx(ag_waddr);
        apr   = routes_pfx(ag_raddr);
        ag_hb = ag_wr && !apw;
        eu    = pl_usr_wr && !ag_hb && !rst;
        for (int s = 0; s < NP; s++)
            ep[s] = pl_pfx_wr[s] && !(ag_wr && apw && int'(pfx_sel) == s) && !rst;
        seen_uack = pl_usr_ack;
        seen_pack = pl_pfx_ack;
        chk("usr_ack", DW'(pl_usr_ack), DW'(eu));
        chk("pfx_ack", DW'(pl_pfx_ack), DW'(ep));
        if (ag_wr && apw) begin
            m_pf[pfx_sel][ag_waddr[PAW-1:0]] = ag_wdata;
            k_pf[pfx_sel][ag_waddr[PAW-1:0]] = 1'b1;
        end else if (ag_wr) begin
            m_hb[ag_waddr] = ag_wdata;
            k_hb[ag_waddr] = 1'b1;
        end
        if (eu) begin
            m_hb[ptr] = pl_usr_wdata;
            k_hb[ptr] = 1'b1;
        end
        for (int s = 0; s < NP; s++) begin
            if (ep[s]) begin
                m_pf[s][pl_pfx_waddr[s*PAW +: PAW]] = pl_pfx_wdata[s*DW +: DW];
                k_pf[s][pl_pfx_waddr[s*PAW +: PAW]] = 1'b1;
            end
        end
        rv = ag_rd && !rst;
        if (apr) begin
            rd = m_pf[pfx_sel][ag_raddr[PAW-1:0]];
            rk = k_pf[pfx_sel][ag_raddr[PAW-1:0]];
        end else begin
            rd = m_hb[ag_raddr];
            rk = k_hb[ag_raddr];
        end
        @(posedge clk);
        if (rst) begin
            ptr = PD; wrp = 1'b0; p1_v = 1'b0;
            exp_rv = 1'b0; last_d = '0; last_k = 1'b1;
        end else begin
            exp_rv = p1_v;
            if (p1_v) begin
                last_d = p1_d;
                last_k = p1_k;
            end
            p1_v = rv; p1_d = rd; p1_k = rk;
            if (ag_eof) begin
                ptr = PD; wrp = 1'b0;
            end else if (eu) begin
                if (ptr == HBD - 1) begin
                    ptr = PD; wrp = 1'b1;
                end else begin
                    ptr++;
                end
            end
        end
        #1;
        chk("rvalid", DW'(ag_rvalid), DW'(exp_rv));
        if (last_k) chk("rdata", ag_rdata, last_d);
        chk("usr_waddr", DW'(usr_waddr), DW'(ptr));
        chk("usr_wrapped", DW'(usr_wrapped), DW'(wrp));
        chk("ecc_err", DW'(ecc_err), '0);
    endtask

    task automatic apply(vec_t v);
        idle_inputs();
        pfx_sel_valid = v.sv;
        pfx_sel       = SW'(v.sel);
        ag_wr         = v.agw;
        ag_waddr      = AW'(v.wa);
        ag_wdata      = v.wd;
        ag_rd         = v.agr;
        ag_raddr      = AW'(v.ra);
        pl_usr_wr     = v.uw;
        pl_usr_wdata  = v.ud;
        pl_pfx_wr     = v.pw;
        pl_pfx_waddr  = {3{6'h30}};
        pl_pfx_wdata  = {DW'('h602), DW'('h601), DW'('h600)};
        step();
    endtask

    initial begin
        for (int i = 0; i < HBD; i++) k_hb[i] = 1'b0;
        for (int s = 0; s < NP; s++)
            for (int i = 0; i < PD; i++) k_pf[s][i] = 1'b0;
        ptr = PD; wrp = 1'b0; p1_v = 1'b0; p1_k = 1'b0; p1_d = '0;
        last_d = '0; last_k = 1'b0; exp_rv = 1'b0;
        seen_uack = 1'b0; seen_pack = '0;

        tbl[0]  = mk(0,0,1,'h10,'h222,0,0,0,0,0,0,0,0,0);
        tbl[1]  = mk(1,0,1,'h10,'h111,0,0,0,0,0,0,0,0,0);
        tbl[2]  = mk(1,2,1,'h10,'h0A5,0,0,0,0,0,0,0,0,0);
        tbl[3]  = mk(1,2,0,0,0,1,'h10,0,0,0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0,0,1,'h10,0,0,0,0,0,1,'h0A5);
        tbl[5]  = mk(0,0,0,0,0,1,'h10,0,0,0,0,0,1,'h111);
        tbl[6]  = mk(1,0,0,0,0,0,0,0,0,0,0,0,1,'h222);
        tbl[7]  = mk(1,0,1,'h100,'h333,0,0,1,'h444,0,0,0,0,0);
        tbl[8]  = mk(1,0,0,0,0,0,0,1,'h444,0,1,0,0,0);
        tbl[9]  = mk(1,0,0,0,0,1,'h40,0,0,0,0,0,0,0);
        tbl[10] = mk(1,0,0,0,0,1,'h100,0,0,0,0,0,1,'h444);
        tbl[11] = mk(1,0,0,0,0,0,0,0,0,0,0,0,1,'h333);
        tbl[12] = mk(1,0,1,'h200,'hDEAD,1,'h200,0,0,0,0,0,0,0);
        tbl[13] = mk(1,1,1,'h20,'hBEEF,1,'h20,0,0,0,0,0,1,'hDEAD);
        tbl[14] = mk(1,1,0,0,0,0,0,0,0,0,0,0,1,'hBEEF);
        tbl[15] = mk(1,0,1,'h30,'h555,0,0,0,0,3'b011,0,3'b010,0,0);
        tbl[16] = mk(1,0,0,0,0,1,'h30,0,0,0,0,0,0,0);
        tbl[17] = mk(1,1,0,0,0,1,'h30,0,0,0,0,0,1,'h555);
        tbl[18] = mk(1,1,0,0,0,0,0,0,0,0,0,0,1,'h601);
        tbl[19] = mk(1,0,0,0,0,0,0,0,0,3'b001,0,3'b001,0,0);
        tbl[20] = mk(1,0,0,0,0,1,'h30,0,0,0,0,0,0,0);
        tbl[21] = mk(1,0,0,0,0,1,'h100,0,0,0,0,0,1,'h600);
        tbl[22] = mk(1,2,0,0,0,1,'h10,0,0,0,0,0,1,'h333);
        tbl[23] = mk(1,2,0,0,0,1,'h200,0,0,0,0,0,1,'h0A5);
        tbl[24] = mk(1,2,0,0,0,0,0,0,0,0,0,0,1,'hDEAD);
        tbl[25] = mk(1,2,0,0,0,0,0,0,0,0,0,0,0,0);

        idle_inputs();
        pfx_sel_valid = 1'b1;
        pfx_sel = '0;
        rst = 1'b1;
        step();
        step();
        chk("rst_waddr", DW'(usr_waddr), DW'('h40));
        chk("rst_rdata", ag_rdata, '0);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d_uack", i), DW'(seen_uack), DW'(tbl[i].eu));
            chk($sformatf("tbl%0d_pack", i), DW'(seen_pack), DW'(tbl[i].ep));
            chk($sformatf("tbl%0d_rv", i), DW'(ag_rvalid), DW'(tbl[i].erv));
            if (tbl[i].erv)
                chk($sformatf("tbl%0d_rd", i), ag_rdata, tbl[i].erd);
        end

        // pointer wrap, then eof coincident with an accepted write
        idle_inputs();
        ag_eof = 1'b1;
        step();
        for (int i = 0; i < HBD - PD; i++) begin
            idle_inputs();
            pl_usr_wr = 1'b1;
            pl_usr_wdata = DW'(i + 'h1000);
            step();
        end
        chk("wrap_ptr", DW'(usr_waddr), DW'('h40));
        chk("wrap_flag", DW'(usr_wrapped), DW'(1));
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            pl_usr_wr = 1'b1;
            pl_usr_wdata = DW'('hC00 + i);
            step();
        end
        idle_inputs();
        pl_usr_wr = 1'b1;
        pl_usr_wdata = DW'('hE0F);
        ag_eof = 1'b1;
        step();
        chk("eof_ptr", DW'(usr_waddr), DW'('h40));
        chk("eof_flag", DW'(usr_wrapped), DW'(0));
        idle_inputs();
        ag_rd = 1'b1;
        ag_raddr = AW'('h43);
        step();
        idle_inputs();
        step();
        chk("eof_land", ag_rdata, DW'('hE0F));

        // reset with reads in flight
        idle_inputs();
        ag_rd = 1'b1; ag_raddr = AW'('h100);
        step();
        ag_raddr = AW'('h200);
        step();
        idle_inputs();
        rst = 1'b1;
        pl_usr_wr = 1'b1;
        pl_pfx_wr = '1;
        step();
        chk("rst_uack", DW'(seen_uack), '0);
        chk("rst_pack", DW'(seen_pack), '0);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step();
            chk("post_rst_rv", DW'(ag_rvalid), '0);
            chk("post_rst_rd", ag_rdata, '0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            pfx_sel_valid = ($urandom_range(0, 7) != 0);
            pfx_sel  = SW'($urandom_range(0, NP - 1));
            ag_wr    = $urandom_range(0, 1) == 1;
            ag_waddr = ($urandom_range(0, 1) == 1)
                     ? AW'($urandom_range(0, 63))
                     : AW'($urandom_range('h40, 'h5F));
            ag_wdata = {$urandom, $urandom, $urandom, $urandom};
            ag_rd    = $urandom_range(0, 9) < 6;
            ag_raddr = ($urandom_range(0, 3) == 0) ? ag_waddr
                     : (($urandom_range(0, 1) == 1)
                        ? AW'($urandom_range(0, 63))
                        : AW'($urandom_range('h40, 'h5F)));
            pl_usr_wr    = $urandom_range(0, 1) == 1;
            pl_usr_wdata = {$urandom, $urandom, $urandom, $urandom};
            pl_pfx_wr    = NP'($urandom_range(0, 7));
            for (int s = 0; s < NP; s++) begin
                pl_pfx_waddr[s*PAW +: PAW] = PAW'($urandom_range(0, 63));
                pl_pfx_wdata[s*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
            ag_eof = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/cr_xp10_decomp_lz77_hb_mp.md
# cr_xp10_decomp_lz77_hb_mp

Parametrised LZ77 history-buffer subsystem for the XP10 decompressor. It holds one main history RAM and `NUM_PFX` independently selectable prefix RAMs. Low addresses route to the selected prefix slot, and all other addresses go to the main buffer. It arbitrates the address-generator (AG) read/write port against payload-loader (PL) user and prefix writes. It adds features the earlier history buffer lacked: explicit slot select, a user-write handshake, an internally owned user write pointer with wrap flag, a read-valid strobe, and read-during-write forwarding.

## Interface
- `DW`, 128, data width in bits
- `HB_DEPTH`, 4096, main buffer entries; `AW = $clog2(HB_DEPTH)`
- `PFX_DEPTH`, 64, entries per prefix slot; `PAW = $clog2(PFX_DEPTH)`; must be < `HB_DEPTH`
- `NUM_PFX`, 3, number of prefix slots (1..8); `SW = max(1,$clog2(NUM_PFX))`
- `clk`  input  1  sole clock
- `rst`  input  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- `ag_wr` / `ag_waddr` / `ag_wdata`  input  1 / AW / DW  AG write
- `ag_rd` / `ag_raddr`  input  1 / AW  AG read request
- `ag_rdata` / `ag_rvalid`  output  DW / 1  read data and its strobe
- `ag_eof`  input  1  end of frame; rewinds user pointer
- `pfx_sel_valid` / `pfx_sel`  input  1 / SW  active prefix slot; static while traffic is in flight
- `pl_pfx_wr` / `pl_pfx_waddr` / `pl_pfx_wdata`  input  NUM_PFX / NUM_PFX*PAW / NUM_PFX*DW  per-slot PL prefix loads
- `pl_pfx_ack`  output  NUM_PFX  per-slot load accepted
- `pl_usr_wr` / `pl_usr_wdata`  input  1 / DW  PL user-data write request
- `pl_usr_ack`  output  1  user write accepted this cycle
- `usr_waddr`  output  AW  current user write pointer
- `usr_wrapped`  output  1  sticky: pointer wrapped since last eof
- `ecc_err`  output  NUM_PFX+1  registered uncorrectable ECC flags; bit `NUM_PFX` is the main buffer

## Operation
- **Routing.** An address below `PFX_DEPTH` with `pfx_sel_valid=1` targets prefix slot `pfx_sel`, at offset `addr[PAW-1:0]`. Every other access targets the main buffer at the full address.
- **Main-buffer write port.** `ag_wr` to the main buffer has priority.
  - `pl_usr_ack = pl_usr_wr && !(ag_wr && ag target is main buffer)`.
  - An accepted user write stores `pl_usr_wdata` at `usr_waddr`.
- **Prefix write port, per slot s.** An AG write to slot s has priority.
  - `pl_pfx_ack[s] = pl_pfx_wr[s] && !(ag write targets s)`.
  - A PL that is not acked holds its request.
- **User pointer.**
  - Resets to `PFX_DEPTH`.
  - Increments by 1 on each `pl_usr_ack`.
  - `HB_DEPTH-1` wraps to `PFX_DEPTH` and sets `usr_wrapped`.
  - `ag_eof` loads `PFX_DEPTH` and clears `usr_wrapped`. This overrides an increment in the same cycle; the coincident acked write still lands at the old pointer.
- **Reads.**
  - Each AG read enables exactly one RAM. The target tag (slot index or main) is pipelined alongside the read.
  - The output mux uses the stage-2 tag.
- **Read-during-write forwarding.** If a cycle-t read and any accepted write hit the same RAM and the same address, the read returns the write data, not the old RAM contents.
- **ECC.** Per-RAM uncorrectable-error outputs are registered one cycle into `ecc_err`.

## Timing
- **Reset values.** `ag_rdata=0`, `ag_rvalid=0`, `pl_usr_ack=0`, `pl_pfx_ack=0`, `usr_waddr=PFX_DEPTH`, `usr_wrapped=0`, `ecc_err=0`.
- **Acks.** `pl_usr_ack` and `pl_pfx_ack` are combinational from the same-cycle requests.
- **Read latency.** `ag_rd` at cycle t gives `ag_rvalid=1` and valid `ag_rdata` at t+2: RAM 1 cycle plus an output register. One read per cycle, fully pipelined. `ag_rdata` holds its last value when `ag_rvalid=0`.
- **Writes.** A write at cycle t is visible to reads issued at t+1 from the RAM, and at t through forwarding.
- **Reset mid-operation.** In-flight reads are discarded; no `ag_rvalid` follows reset.
- **Mid-flight slot change.** Changing `pfx_sel` while reads are in flight is allowed. Returned data follows the slot captured at issue.

## Structure
- Shared package `cr_xp10_decompPKG` holds:
  - the target-tag typedef, an enum of `TGT_PFX0..` and `TGT_HB`;
  - default depth constants, with `PFX_DEPTH` tied to `CR_LZ_PRFX_SZ`.
- RAMs are `nx_ram_1r1w` instances: one with depth `HB_DEPTH`, plus `NUM_PFX` instances via generate.
- The BIMC chain is serialised through all RAM instances; its ports follow the codebase standard and are omitted here.
- Natural sub-module: `cr_xp10_decomp_hb_rdpipe`. It contains the tag pipeline, forwarding compare/capture, output mux, and `rvalid`.

## Test plan
- **Routing.** `pfx_sel_valid=1`, `pfx_sel=2`, AG write 0x0A5 to addr 0x010, then read 0x010 → `ag_rvalid` at t+2 with 0x0A5; slot 0 and main buffer unchanged.
- **User-write arbitration.** `ag_wr` to main addr 0x100 and `pl_usr_wr` in the same cycle → `pl_usr_ack=0`, user write stalls one cycle, then lands at 0x040.
- **Pointer wrap and eof.** 4032 user writes → pointer wraps to 0x040 and `usr_wrapped=1`. `ag_eof` coincident with an acked write → write lands at the old pointer, pointer becomes 0x040, `usr_wrapped=0`.
- **Forwarding.** Same-cycle write 0xDEAD and read to addr 0x200 → `ag_rdata=0xDEAD` at t+2; same again on prefix slot 1.
- **Prefix-load conflict.** AG write and `pl_pfx_wr[0]` both target slot 0 → `pl_pfx_ack[0]=0` and AG data is stored; `pl_pfx_wr[1]` concurrently acked.
- **Back-to-back reads and reset.** Reads every cycle alternating main/prefix → in-order data, one `rvalid` per cycle. Assert `rst` with 2 reads in flight → no `rvalid` afterwards; all outputs at reset values.
